// File: rtl/ebus_xfer_ctl.sv
// ebus_xfer_ctl -- EBOX-side EBUS transfer controller.
// Runs one CONO/CONI/DATAO/DATAI transaction per accepted request:
// IDLE -> SETUP (address setup) -> DEMAND (wait for xfer or timeout)
// -> RELEASE (wait for xfer to drop) -> IDLE with a one-cycle done pulse.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   req/reqCS/reqFunc/reqData  request strobe and transfer parameters
//   busy, done, err, nxd       status; err/nxd qualify the done pulse
//   rdData                     data captured on CONI/DATAI
//   ebusCS/ebusFunc/ebusDemand EBUS control toward devices
//   ebusAck/ebusXfer/ebusData  EBUS responses from devices
//   drv                        {data[0:35], driving} for the EBUS mux slot
module ebus_xfer_ctl #(
   parameter logic [7:0] TIMEOUT = 8'd64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic [0:6]  reqCS,
   input  logic [0:2]  reqFunc,
   input  logic [0:35] reqData,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic        nxd,
   output logic [0:35] rdData,
   output logic [0:6]  ebusCS,
   output logic [0:2]  ebusFunc,
   output logic        ebusDemand,
   input  logic        ebusAck,
   input  logic        ebusXfer,
   input  logic [0:35] ebusData,
   output logic [0:36] drv
);

   typedef enum logic [1:0] {IDLE, SETUP, DEMAND, RELEASE} state_t;

   // TIMEOUT=0 is treated as 1: the last allowed DEMAND count is then 0.
   localparam logic [7:0] TMO_LAST = (TIMEOUT == 8'd0) ? 8'd0 : TIMEOUT - 8'd1;

   state_t      state, stateNext;
   logic [0:6]  csLat;
   logic [0:2]  funcLat;
   logic [0:35] dataLat;
   logic [7:0]  cnt;
   logic        ackSeen, errPend, nxdPend;
   logic        reqLegal, isRead, cntSat, tmoHit;

   // Codes 0xx are the four legal functions; bit 2 set means a read.
   assign reqLegal = ~reqFunc[0];
   assign isRead   = funcLat[2];
   assign cntSat   = (cnt == 8'hFF);
   assign tmoHit   = (cnt == TMO_LAST);

   always_comb begin
      stateNext  = state;
      busy       = 1'b1;
      ebusDemand = 1'b0;
      ebusCS     = csLat;
      ebusFunc   = funcLat;
      drv        = '0;
      case (state)
         IDLE: begin
            busy     = 1'b0;
            ebusCS   = '0;
            ebusFunc = '0;
            if (req && reqLegal) stateNext = SETUP;
         end
         SETUP: stateNext = DEMAND;
         DEMAND: begin
            ebusDemand = 1'b1;
            if (!isRead) drv = {dataLat, 1'b1};
            if (ebusXfer || tmoHit) stateNext = RELEASE;
         end
         RELEASE: begin
            if (!ebusXfer || cntSat) stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         csLat   <= '0;
         funcLat <= '0;
         dataLat <= '0;
         cnt     <= '0;
         ackSeen <= 1'b0;
         errPend <= 1'b0;
         nxdPend <= 1'b0;
         rdData  <= '0;
         done    <= 1'b0;
         err     <= 1'b0;
         nxd     <= 1'b0;
      end else begin
         state <= stateNext;
         done  <= 1'b0;
         err   <= 1'b0;
         nxd   <= 1'b0;
         case (state)
            IDLE: begin
               cnt     <= '0;
               errPend <= 1'b0;
               nxdPend <= 1'b0;
               if (req) begin
                  if (reqLegal) begin
                     csLat   <= reqCS;
                     funcLat <= reqFunc;
                     dataLat <= reqData;
                     ackSeen <= 1'b0;
                  end else begin
                     // Illegal function: complete immediately with error.
                     done <= 1'b1;
                     err  <= 1'b1;
                  end
               end
            end
            SETUP: cnt <= '0;
            DEMAND: begin
               if (!cntSat) cnt <= cnt + 8'd1;
               if (ebusAck) ackSeen <= 1'b1;
               if (ebusXfer) begin
                  if (isRead) rdData <= ebusData;
               end else if (tmoHit) begin
                  errPend <= 1'b1;
                  // An ack in this very cycle still counts as a device present.
                  nxdPend <= ~(ackSeen | ebusAck);
               end
            end
            RELEASE: begin
               if (!cntSat) cnt <= cnt + 8'd1;
               if (stateNext == IDLE) begin
                  done <= 1'b1;
                  err  <= errPend | cntSat;
                  nxd  <= nxdPend;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ebus_xfer_ctl.sv
// Bench for ebus_xfer_ctl: table-driven cycle vectors on a default-TIMEOUT
// instance, plus hand-written sequences for timeout, reset, saturation and
// back-to-back behaviour on TIMEOUT=64/4/0 instances.
module tb_ebus_xfer_ctl;

   logic        clk = 1'b0;
   logic        reset;
   logic        reqA, reqB, reqZ;
   logic [0:6]  reqCS;
   logic [0:2]  reqFunc;
   logic [0:35] reqData;
   logic        ebusAck, ebusXfer;
   logic [0:35] ebusData;

   logic        aBusy, aDone, aErr, aNxd, aDem;
   logic [0:35] aRd;
   logic [0:6]  aCs;
   logic [0:2]  aFn;
   logic [0:36] aDrv;
   logic        bBusy, bDone, bErr, bNxd, bDem;
   logic [0:35] bRd;
   logic [0:6]  bCs;
   logic [0:2]  bFn;
   logic [0:36] bDrv;
   logic        zBusy, zDone, zErr, zNxd, zDem;
   logic [0:35] zRd;
   logic [0:6]  zCs;
   logic [0:2]  zFn;
   logic [0:36] zDrv;

   always #5 clk = ~clk;

   ebus_xfer_ctl dutA (
      .clk(clk), .reset(reset), .req(reqA), .reqCS(reqCS), .reqFunc(reqFunc), .reqData(reqData),
      .busy(aBusy), .done(aDone), .err(aErr), .nxd(aNxd), .rdData(aRd), .ebusCS(aCs),
      .ebusFunc(aFn), .ebusDemand(aDem), .ebusAck(ebusAck), .ebusXfer(ebusXfer),
      .ebusData(ebusData), .drv(aDrv));

   ebus_xfer_ctl #(.TIMEOUT(8'd4)) dutB (
      .clk(clk), .reset(reset), .req(reqB), .reqCS(reqCS), .reqFunc(reqFunc), .reqData(reqData),
      .busy(bBusy), .done(bDone), .err(bErr), .nxd(bNxd), .rdData(bRd), .ebusCS(bCs),
      .ebusFunc(bFn), .ebusDemand(bDem), .ebusAck(ebusAck), .ebusXfer(ebusXfer),
      .ebusData(ebusData), .drv(bDrv));

   ebus_xfer_ctl #(.TIMEOUT(8'd0)) dutZ (
      .clk(clk), .reset(reset), .req(reqZ), .reqCS(reqCS), .reqFunc(reqFunc), .reqData(reqData),
      .busy(zBusy), .done(zDone), .err(zErr), .nxd(zNxd), .rdData(zRd), .ebusCS(zCs),
      .ebusFunc(zFn), .ebusDemand(zDem), .ebusAck(ebusAck), .ebusXfer(ebusXfer),
      .ebusData(ebusData), .drv(zDrv));

   localparam logic [35:0] D1 = 36'o123456701234;
   localparam logic [35:0] D2 = 36'o777000111222;

   typedef struct {
      logic        rq;
      logic [2:0]  fn;
      logic [6:0]  cs;
      logic [35:0] wd;
      logic        ack, xf;
      logic [35:0] bd;
      logic        eBusy, eDem, eDrv, eDone, eErr, eNxd;
      logic [6:0]  eCs;
      logic [2:0]  eFn;
      logic        chkRd;
      logic [35:0] eRd;
   } vec_t;

   vec_t tbl[$];
   int   nCmp = 0;
   int   nFail = 0;

   function automatic vec_t mk(logic rq, logic [2:0] fn, logic [6:0] cs, logic [35:0] wd,
                               logic ack, logic xf, logic [35:0] bd,
                               logic eBusy, logic eDem, logic eDrv, logic eDone, logic eErr,
                               logic eNxd, logic [6:0] eCs, logic [2:0] eFn,
                               logic chkRd, logic [35:0] eRd);
      vec_t v;
      v.rq = rq; v.fn = fn; v.cs = cs; v.wd = wd; v.ack = ack; v.xf = xf; v.bd = bd;
      v.eBusy = eBusy; v.eDem = eDem; v.eDrv = eDrv; v.eDone = eDone; v.eErr = eErr;
      v.eNxd = eNxd; v.eCs = eCs; v.eFn = eFn; v.chkRd = chkRd; v.eRd = eRd;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nCmp++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s @%0t: got %0h, want %0h", nm, $time, act, exp);
      end
   endtask

   task automatic idleInputs();
      reqA = 0; reqB = 0; reqZ = 0; reqCS = '0; reqFunc = '0; reqData = '0;
      ebusAck = 0; ebusXfer = 0; ebusData = '0;
   endtask

   // TIMEOUT=4 instance: CONI with optional ack at cycle 3 and optional xfer at cycle 5.
   task automatic runTmo(input logic ackAt3, input logic xfAt5);
      for (int c = 0; c <= 8; c++) begin
         @(negedge clk);
         if (c == 1) begin chk("tmo_busy1", bBusy, 1); chk("tmo_dem1", bDem, 0); end
         if (c >= 2 && c <= 5) chk($sformatf("tmo_dem_c%0d", c), bDem, 1);
         if (c == 6) begin chk("tmo_dem6", bDem, 0); chk("tmo_busy6", bBusy, 1); end
         if (c == 7) begin
            chk("tmo_done", bDone, 1);
            chk("tmo_err", bErr, !xfAt5);
            chk("tmo_nxd", bNxd, !xfAt5 && !ackAt3);
         end
         if (c == 8) chk("tmo_done_clr", bDone, 0);
         idleInputs();
         if (c == 0) begin reqB = 1; reqFunc = 3'b001; reqCS = 7'o3; end
         if (c == 3) ebusAck = ackAt3;
         if (c == 5) ebusXfer = xfAt5;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1);
   end

   initial begin
      int doneCnt;
      idleInputs();
      reset = 1;
      repeat (3) @(negedge clk);
      chk("rst_busy", aBusy, 0);   chk("rst_done", aDone, 0);
      chk("rst_err", aErr, 0);     chk("rst_nxd", aNxd, 0);
      chk("rst_rd", aRd, 0);       chk("rst_cs", aCs, 0);
      chk("rst_fn", aFn, 0);       chk("rst_dem", aDem, 0);
      chk("rst_drv", aDrv, 0);     chk("rst_b_busy", bBusy, 0);
      reset = 0;

      // DATAI, xfer at cycle 6
      tbl.push_back(mk(1,3'd3,7'o20,0,0,0,0,   0,0,0,0,0,0, 7'o0,3'd0, 1,0));
      tbl.push_back(mk(0,0,0,0,0,0,0,          1,0,0,0,0,0, 7'o20,3'd3, 0,0));
      for (int c = 2; c <= 5; c++)
         tbl.push_back(mk(0,0,0,0,0,0,0,       1,1,0,0,0,0, 7'o20,3'd3, 1,0));
      tbl.push_back(mk(0,0,0,0,0,1,D2,         1,1,0,0,0,0, 7'o20,3'd3, 0,0));
      tbl.push_back(mk(0,0,0,0,0,0,0,          1,0,0,0,0,0, 7'o20,3'd3, 1,D2));
      tbl.push_back(mk(0,0,0,0,0,0,0,          0,0,0,1,0,0, 7'o0,3'd0, 1,D2));
      tbl.push_back(mk(0,0,0,0,0,0,0,          0,0,0,0,0,0, 7'o0,3'd0, 1,D2));
      // DATAO, ack at 2, xfer at 3, drop at 4; rdData must hold D2
      tbl.push_back(mk(1,3'd2,7'o14,D1,0,0,0,  0,0,0,0,0,0, 7'o0,3'd0, 0,0));
      tbl.push_back(mk(0,0,0,0,0,0,0,          1,0,0,0,0,0, 7'o14,3'd2, 0,0));
      tbl.push_back(mk(0,0,0,0,1,0,0,          1,1,1,0,0,0, 7'o14,3'd2, 0,0));
      tbl.push_back(mk(0,0,0,0,0,1,0,          1,1,1,0,0,0, 7'o14,3'd2, 0,0));
      tbl.push_back(mk(0,0,0,0,0,0,0,          1,0,0,0,0,0, 7'o14,3'd2, 0,0));
      tbl.push_back(mk(0,0,0,0,0,0,0,          0,0,0,1,0,0, 7'o0,3'd0, 1,D2));
      tbl.push_back(mk(0,0,0,0,0,0,0,          0,0,0,0,0,0, 7'o0,3'd0, 0,0));
      // Illegal functions 101 and 110
      tbl.push_back(mk(1,3'd5,7'o33,0,0,0,0,   0,0,0,0,0,0, 7'o0,3'd0, 0,0));
      tbl.push_back(mk(0,0,0,0,0,0,0,          0,0,0,1,1,0, 7'o0,3'd0, 1,D2));
      tbl.push_back(mk(1,3'd6,7'o33,0,0,0,0,   0,0,0,0,0,0, 7'o0,3'd0, 0,0));
      tbl.push_back(mk(0,0,0,0,0,0,0,          0,0,0,1,1,0, 7'o0,3'd0, 0,0));
      tbl.push_back(mk(0,0,0,0,0,0,0,          0,0,0,0,0,0, 7'o0,3'd0, 0,0));

      foreach (tbl[i]) begin
         @(negedge clk);
         chk($sformatf("v%0d_busy", i), aBusy, tbl[i].eBusy);
         chk($sformatf("v%0d_dem", i),  aDem,  tbl[i].eDem);
         chk($sformatf("v%0d_done", i), aDone, tbl[i].eDone);
         chk($sformatf("v%0d_err", i),  aErr,  tbl[i].eErr);
         chk($sformatf("v%0d_nxd", i),  aNxd,  tbl[i].eNxd);
         chk($sformatf("v%0d_cs", i),   aCs,   tbl[i].eCs);
         chk($sformatf("v%0d_fn", i),   aFn,   tbl[i].eFn);
         chk($sformatf("v%0d_drv", i),  aDrv,  tbl[i].eDrv ? {D1, 1'b1} : 37'd0);
         if (tbl[i].chkRd) chk($sformatf("v%0d_rd", i), aRd, tbl[i].eRd);
         reqA = tbl[i].rq; reqFunc = tbl[i].fn; reqCS = tbl[i].cs; reqData = tbl[i].wd;
         ebusAck = tbl[i].ack; ebusXfer = tbl[i].xf; ebusData = tbl[i].bd;
      end

      // Timeout: no ack; ack but no xfer; xfer on the timeout cycle
      runTmo(0, 0);
      runTmo(1, 0);
      runTmo(0, 1);

      // TIMEOUT=0 behaves as 1: a single DEMAND cycle
      for (int c = 0; c <= 4; c++) begin
         @(negedge clk);
         if (c == 2) chk("t0_dem2", zDem, 1);
         if (c == 3) begin chk("t0_dem3", zDem, 0); chk("t0_busy3", zBusy, 1); end
         if (c == 4) begin chk("t0_done", zDone, 1); chk("t0_err", zErr, 1); chk("t0_nxd", zNxd, 1); end
         idleInputs();
         if (c == 0) begin reqZ = 1; reqFunc = 3'b001; end
      end

      // Reset in DEMAND with xfer pending, then a normal transfer
      for (int c = 0; c <= 14; c++) begin
         @(negedge clk);
         if (c == 3) chk("rd_dem3", aDem, 1);
         if (c == 4) begin
            chk("rs_dem", aDem, 0); chk("rs_drv", aDrv, 0);
            chk("rs_busy", aBusy, 0); chk("rs_rd", aRd, 0);
         end
         if (c >= 5 && c <= 9) chk($sformatf("rs_nodone_c%0d", c), aDone, 0);
         if (c == 12) chk("rs2_drv", aDrv, {D1, 1'b1});
         if (c == 14) begin chk("rs2_done", aDone, 1); chk("rs2_err", aErr, 0); end
         idleInputs();
         reset = (c == 3);
         if (c == 0 || c == 10) begin reqA = 1; reqFunc = 3'b010; reqCS = 7'o5; reqData = D1; end
         if (c == 3 || c == 12) ebusXfer = 1;
      end

      // Saturation: xfer held high forever after cycle 2
      for (int c = 0; c <= 259; c++) begin
         @(negedge clk);
         if (c == 257) chk("sat_busy", aBusy, 1);
         if (c == 258) begin
            chk("sat_done", aDone, 1); chk("sat_err", aErr, 1);
            chk("sat_nxd", aNxd, 0);   chk("sat_rd", aRd, 36'o1);
         end
         idleInputs();
         if (c == 0) begin reqA = 1; reqFunc = 3'b011; reqCS = 7'o1; end
         if (c >= 2 && c < 258) begin ebusXfer = 1; ebusData = 36'o1; end
      end

      // Back-to-back: req held through the first done, pulses while busy ignored
      doneCnt = 0;
      for (int c = 0; c <= 15; c++) begin
         @(negedge clk);
         if (aDone) doneCnt++;
         if (c == 4) chk("b2b_done1", aDone, 1);
         if (c == 5) chk("b2b_busy5", aBusy, 1);
         if (c == 8) chk("b2b_done2", aDone, 1);
         if (c == 9) chk("b2b_idle9", aBusy, 0);
         idleInputs();
         reqA = (c <= 4) || (c == 6) || (c == 7);
         reqFunc = 3'b010; reqCS = 7'o7; reqData = D1;
         ebusXfer = (c == 2) || (c == 6);
      end
      chk("b2b_count", doneCnt, 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
      $finish;
   end

endmodule
